// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end: size codes, FSM states,
// default widths and the alignment rule.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP,
        ST_ERR
    } state_t;

    // Size 11 is never legal; halves need an even address, words a multiple of 4.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~offset[0];
            SZ_WORD: return (offset == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from a memory
// word, and merges sub-word store data into a word. Lanes are little-endian.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane   = word[{offset, 3'b000} +: 8];
        halfLane   = word[{offset[1], 4'b0000} +: 16];
        loadData   = word;
        mergedWord = word;
        case (size)
            SZ_BYTE: begin
                loadData = {{24{isSigned & byteLane[7]}}, byteLane};
                mergedWord[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                loadData = {{16{isSigned & halfLane[15]}}, halfLane};
                mergedWord[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                loadData   = word;
                mergedWord = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-wide data memory: handshake, alignment
// check, read-modify-write for sub-word stores and extended load responses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] Address,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] ReadData
);

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] reqAddrQ;
    logic [1:0]        reqSizeQ;
    logic              reqWriteQ;
    logic              reqSignedQ;
    logic [DATA_W-1:0] reqWdataQ;
    logic [DATA_W-1:0] dataQ;
    logic              accept;
    logic              reqBad;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] mergedWord;

    assign accept = req_valid & req_ready;
    assign reqBad = ~isAligned(req_size, req_addr[1:0]);

    mem_lane_align uAlign (
        .offset    (reqAddrQ[1:0]),
        .size      (reqSizeQ),
        .isSigned  (reqSignedQ),
        .word      (ReadData),
        .wdata     (reqWdataQ),
        .loadData  (loadData),
        .mergedWord(mergedWord)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            reqAddrQ   <= '0;
            reqSizeQ   <= '0;
            reqWriteQ  <= 1'b0;
            reqSignedQ <= 1'b0;
            reqWdataQ  <= '0;
            dataQ      <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                reqAddrQ   <= req_addr;
                reqSizeQ   <= req_size;
                reqWriteQ  <= req_write;
                reqSignedQ <= req_signed;
                reqWdataQ  <= req_wdata;
                dataQ      <= req_wdata;
            end else if (state == ST_CAP) begin
                // dataQ becomes the word to write back or the load result.
                dataQ <= reqWriteQ ? mergedWord : loadData;
            end
        end
    end

    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        writeData  = '0;
        Address    = {reqAddrQ[ADDR_W-1:2], 2'b00};
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (reqBad)
                        nextState = ST_ERR;
                    else if (req_write && req_size == SZ_WORD)
                        nextState = ST_WR;
                    else
                        nextState = ST_RD;
                end
            end
            ST_RD: begin
                MemRead   = 1'b1;
                nextState = ST_CAP;
            end
            ST_CAP: begin
                nextState = reqWriteQ ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                MemWrite  = 1'b1;
                writeData = dataQ;
                nextState = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = reqWriteQ ? '0 : dataQ;
                nextState  = ST_IDLE;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_error = 1'b1;
                nextState  = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end that sits directly upstream of the word-wide Memory block and drives its clock/Address/MemRead/MemWrite/writeData/ReadData interface. It accepts byte, halfword and word requests over a valid/ready handshake, checks alignment, and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data with a single-cycle response pulse. The pipeline memory stage uses it as its only path to data memory.

Parameters:
ADDR_W, 8, byte-address width; matches the Memory Address port.
DATA_W, 32, word width; fixed at 32 because the byte-lane logic assumes 4 lanes.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE (combinational from state).
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed  in  1  sign-extend loads; ignored for stores.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
resp_valid  out  1  one-cycle response pulse; no backpressure.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_error  out  1  valid with resp_valid; misaligned access or illegal size.
Address  out  ADDR_W  word address to Memory, {addr[7:2],2'b00}.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
writeData  out  DATA_W  word to write.
ReadData  in  DATA_W  memory read data; valid in the cycle after the edge that samples MemRead.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; resp_valid=0, resp_rdata=0, resp_error=0, MemRead=0, MemWrite=0, Address=0, writeData=0; req_ready=1; latched request cleared.
- Memory contract: a write commits at the rising edge where MemWrite=1. A read sampled at edge T gives ReadData valid from T until the next edge.
- Handshake: accept at an edge with req_valid && req_ready. Latch addr/size/write/signed/wdata. In non-IDLE states req_valid is ignored and the requester holds the request.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always illegal. Any violation goes to ERR and drives no memory strobes.
- States: IDLE, RD, CAP, WR, RESP, ERR.
  - IDLE->ERR on a bad request.
  - IDLE->WR on a word store.
  - IDLE->RD on a load or sub-word store.
  - RD (MemRead=1) -> CAP.
  - CAP: ReadData registered at the exiting edge. Sub-word store goes to WR with the merged word; load goes to RESP with extracted data.
  - WR (MemWrite=1, writeData=word) -> RESP.
  - RESP and ERR: resp_valid=1 for exactly one cycle -> IDLE.
- Latency from accept edge to resp_valid cycle: error 1, word store 2, load 3, sub-word store 4. Throughput is one request per (latency+1) cycles.
- Strobes are asserted only in RD and WR, for exactly one cycle each. MemRead and MemWrite are never high together. Address is held for the whole transaction.
- Lanes are little-endian: byte k = bits[8k+7:8k] with k=addr[1:0]; half h = bits[16h+15:16h] with h=addr[1].
- Store merge replaces only the addressed lane(s) with the low bits of req_wdata.
- Load extension: req_signed=1 replicates the lane MSB; otherwise zero-fill. A word load returns the raw word.
- Reset mid-operation aborts immediately with no response. Reset before the WR commit edge leaves memory unchanged.

Decomposition:
- Shared package mem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the ADDR_W/DATA_W defaults.
- One combinational sub-module, mem_lane_align, covers lane extract plus sign/zero extension and lane merge. It takes offset, size, signed, word and wdata as inputs.

Test Plan:
1. Word store 0x00000002 @0x04, then word load @0x04 -> MemWrite high exactly 1 cycle with Address=0x04; resp at +2 and +3 cycles; load resp_rdata=0x00000002, resp_error=0.
2. Word store 0x11223344 @0x08, byte store 0xA5 @0x09, word load @0x08 -> 0x1122A544; MemRead then MemWrite each asserted once for the byte store.
3. Loads after test 2:
   - signed byte @0x09 -> 0xFFFFFFA5
   - unsigned byte @0x09 -> 0x000000A5
   - signed half @0x0A -> 0x00001122
   - signed half store 0x8001 @0x0A, then signed half load -> 0xFFFF8001
4. Word load @0x06, half store @0x03, size=11 @0x00 -> each gives resp_valid 1 cycle after accept with resp_error=1, resp_rdata=0; MemRead and MemWrite stay 0.
5. Byte store 0x00 @0x08 with reset_n pulsed low while in CAP -> no MemWrite, no resp_valid, req_ready=1; word @0x08 still reads 0x1122A544.
6. req_valid held high across two word loads @0x04 and @0x08 -> second accepted only at the edge after the first resp_valid cycle; responses 0x00000002 then 0x1122A544, 4 cycles apart.
